immediate_generate_pipe: RTL and testbench

Parametrised, registered successor to the combinational immediate generator, placed at the ID→EX boundary. It decodes instruction[31:7] into an XLEN-wide immediate, selected by the existing 3-bit IMM_SEL encoding plus a new CSR-zimm mode. Results pass through a 2-entry skid buffer with valid/ready handshakes, a per-entry tag, and a synchronous flush, so the decode stage can stall or kill without losing or duplicating immediates.

---
 rtl/immediate_generate_pipe.sv | 139 +++++++++++++
 tb/tb_immediate_generate_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_generate_pipe.sv
// Registered immediate generator at the ID->EX boundary: decodes instruction[31:7]
// into an XLEN immediate and holds results in a 2-entry valid/ready skid buffer.
module immediate_generate_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [24:0]      IN,
  input  logic [2:0]       IMM_SEL,
  input  logic [TAG_W-1:0] IN_TAG,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FLUSH,
  output logic [XLEN-1:0]  OUT,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  typedef enum logic [2:0] {
    SEL_U     = 3'b000,
    SEL_J     = 3'b001,
    SEL_S     = 3'b010,
    SEL_B     = 3'b011,
    SEL_I     = 3'b100,
    SEL_SHAMT = 3'b101,
    SEL_IU    = 3'b110,
    SEL_ZIMM  = 3'b111
  } sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  entry_t          in_ent, head, skid;
  state_t          state, state_nxt;
  logic            in_ready_q;
  logic            accept, pop;
  logic            head_ld, head_from_skid, skid_ld;

  // Decode: sign-extending formats start from all-sign and overwrite the low field.
  always_comb begin
    dec_imm = {XLEN{IN[24]}};
    case (sel_t'(IMM_SEL))
      SEL_U: dec_imm[31:0] = {IN[24:5], 12'b0};
      SEL_J: dec_imm[20:0] = {IN[24], IN[12:5], IN[13], IN[23:14], 1'b0};
      SEL_S: dec_imm[11:0] = {IN[24:18], IN[4:0]};
      SEL_B: dec_imm[12:0] = {IN[24], IN[0], IN[23:18], IN[4:1], 1'b0};
      SEL_I: dec_imm[11:0] = IN[24:13];
      SEL_SHAMT: begin
        dec_imm = '0;
        if (XLEN == 64) dec_imm[5:0] = IN[18:13];
        else            dec_imm[4:0] = IN[17:13];
      end
      SEL_IU: begin
        dec_imm       = '0;
        dec_imm[11:0] = IN[24:13];
      end
      SEL_ZIMM: begin
        dec_imm      = '0;
        dec_imm[4:0] = IN[12:8];
      end
      default: dec_imm = '0;
    endcase
  end

  assign in_ent    = '{imm: dec_imm, tag: IN_TAG};
  assign accept    = IN_VALID & in_ready_q;
  assign pop       = (state != EMPTY) & OUT_READY;

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (state != EMPTY);
  assign OUT       = head.imm;
  assign OUT_TAG   = head.tag;

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          head_ld   = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_ld = 1'b1;
        end else if (accept) begin
          skid_ld   = 1'b1;
          state_nxt = FULL;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything: same-cycle input is dropped, a same-cycle pop still happened.
    if (FLUSH) begin
      state_nxt = EMPTY;
      head_ld   = 1'b0;
      skid_ld   = 1'b0;
    end
  end

  // in_ready_q is the registered image of (state != FULL), so OUT_READY never reaches IN_READY combinationally.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= EMPTY;
      head       <= '0;
      skid       <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (head_ld) head <= head_from_skid ? skid : in_ent;
      if (skid_ld) skid <= in_ent;
    end
  end

endmodule

// File: tb/tb_immediate_generate_pipe.sv
// Bench for immediate_generate_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against a queue model that decodes immediates from RISC-V instruction fields.
module tb_immediate_generate_pipe;

  localparam int TAG_W = 5;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [24:0]      IN;
  logic [2:0]       IMM_SEL;
  logic [TAG_W-1:0] IN_TAG;
  logic             IN_VALID;
  logic             FLUSH;
  logic             OUT_READY;

  logic             rdy32, rdy64, vld32, vld64;
  logic [31:0]      out32;
  logic [63:0]      out64;
  logic [TAG_W-1:0] tag32, tag64;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  immediate_generate_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .CLK(CLK), .RESET(RESET), .IN(IN), .IMM_SEL(IMM_SEL), .IN_TAG(IN_TAG),
    .IN_VALID(IN_VALID), .IN_READY(rdy32), .FLUSH(FLUSH), .OUT(out32),
    .OUT_TAG(tag32), .OUT_VALID(vld32), .OUT_READY(OUT_READY));

  immediate_generate_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .CLK(CLK), .RESET(RESET), .IN(IN), .IMM_SEL(IMM_SEL), .IN_TAG(IN_TAG),
    .IN_VALID(IN_VALID), .IN_READY(rdy64), .FLUSH(FLUSH), .OUT(out64),
    .OUT_TAG(tag64), .OUT_VALID(vld64), .OUT_READY(OUT_READY));

  typedef struct {
    logic [31:0]      e32;
    logic [63:0]      e64;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  bit   exp_rdy = 1'b0;

  // Architectural immediate from the full instruction word, per RISC-V format.
  function automatic logic [63:0] ref_imm(input logic [24:0] f, input logic [2:0] sel, input bit is64);
    logic [31:0]        ins;
    logic signed [20:0] j;
    logic signed [11:0] s;
    logic signed [12:0] b;
    longint             v;
    ins = {f, 7'b0};
    case (sel)
      3'd0: v = longint'($signed(ins & 32'hFFFF_F000));
      3'd1: begin j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = longint'(j); end
      3'd2: begin s = {ins[31:25], ins[11:7]}; v = longint'(s); end
      3'd3: begin b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = longint'(b); end
      3'd4: begin s = ins[31:20]; v = longint'(s); end
      3'd5: v = is64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: v = longint'(ins[31:20]);
      default: v = longint'(ins[19:15]);
    endcase
    return v;
  endfunction

  // Advance the model across the coming edge using the inputs now driven, then step to the next negedge.
  task automatic tick();
    bit   acc, pp;
    ent_t e;
    acc = IN_VALID && exp_rdy;
    pp  = OUT_READY && (q.size() > 0);
    if (!RESET) begin
      q.delete();
      exp_rdy = 1'b0;
    end else if (FLUSH) begin
      q.delete();
      exp_rdy = 1'b1;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.e32 = ref_imm(IN, IMM_SEL, 1'b0);
        e.e64 = ref_imm(IN, IMM_SEL, 1'b1);
        e.tag = IN_TAG;
        q.push_back(e);
      end
      exp_rdy = (q.size() < 2);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1; FLUSH = 1'b0;
    IN = 25'h1FFFFFF; IMM_SEL = 3'd4; IN_TAG = 5'd3;
    tick(); tick();
    total++; if ({out32, tag32} !== '0) begin bad++; $display("FAIL reset_out32 got=%h/%h exp=0/0", out32, tag32); end
    total++; if ({out64, tag64} !== '0) begin bad++; $display("FAIL reset_out64 got=%h/%h exp=0/0", out64, tag64); end
    total++; if ({vld32, vld64, rdy32, rdy64} !== 4'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=0000", {vld32, vld64, rdy32, rdy64}); end
    RESET = 1'b1; IN_VALID = 1'b0;
    tick();
    total++; if ({rdy32, rdy64} !== 2'b11) begin bad++; $display("FAIL reset_release_rdy got=%b exp=11", {rdy32, rdy64}); end
    total++; if ({vld32, vld64} !== 2'b00) begin bad++; $display("FAIL reset_release_vld got=%b exp=00", {vld32, vld64}); end
  endtask

  task automatic test_known();
    logic [31:0] ins   [5] = '{32'hFFF00093, 32'h800000B7, 32'h03F09093, 32'h3412A073, 32'hFE000EE3};
    logic [2:0]  sels  [5] = '{3'd4, 3'd0, 3'd5, 3'd7, 3'd3};
    logic [31:0] exp32 [5] = '{32'hFFFFFFFF, 32'h80000000, 32'd31, 32'd5, 32'hFFFFFFFC};
    logic [63:0] exp64 [5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'd63, 64'd5, 64'hFFFFFFFFFFFFFFFC};
    logic [31:0] w;
    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = ins[i];
      IN = w[31:7]; IMM_SEL = sels[i]; IN_TAG = 5'(i + 20); IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      total++; if (out32 !== exp32[i] || vld32 !== 1'b1) begin bad++; $display("FAIL known32_%0d got=%h v=%b exp=%h", i, out32, vld32, exp32[i]); end
      total++; if (out64 !== exp64[i] || vld64 !== 1'b1) begin bad++; $display("FAIL known64_%0d got=%h v=%b exp=%h", i, out64, vld64, exp64[i]); end
      total++; if (tag32 !== 5'(i + 20) || tag64 !== 5'(i + 20)) begin bad++; $display("FAIL known_tag_%0d got=%0d/%0d exp=%0d", i, tag32, tag64, i + 20); end
      tick();
    end
  endtask

  task automatic test_stall();
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    IN = 25'($urandom()); IMM_SEL = 3'd4; IN_TAG = 5'd1;
    tick();
    total++; if (tag32 !== 5'd1 || vld32 !== 1'b1 || rdy32 !== 1'b1) begin bad++; $display("FAIL stall_a got tag=%0d v=%b r=%b exp tag=1 v=1 r=1", tag32, vld32, rdy32); end
    IN = 25'($urandom()); IMM_SEL = 3'd2; IN_TAG = 5'd2;
    tick();
    total++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin bad++; $display("FAIL stall_full_rdy got=%b%b exp=00", rdy32, rdy64); end
    IN = 25'($urandom()); IMM_SEL = 3'd1; IN_TAG = 5'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (tag32 !== 5'd1 || out32 !== q[0].e32 || out64 !== q[0].e64 || rdy32 !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d got tag=%0d out=%h r=%b exp tag=1 out=%h r=0", k, tag32, out32, rdy32, q[0].e32);
      end
    end
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (vld32 !== 1'b1 || vld64 !== 1'b1 || tag32 !== 5'(k + 1) || out32 !== q[0].e32 || out64 !== q[0].e64) begin
        bad++; $display("FAIL stall_drain_%0d got v=%b tag=%0d out=%h exp v=1 tag=%0d out=%h", k, vld32, tag32, out32, k + 1, q[0].e32);
      end
      tick();
      if (k == 1) IN_VALID = 1'b0;
    end
    total++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b%b exp=00", vld32, vld64); end
  endtask

  task automatic test_flush();
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    IN = 25'($urandom()); IMM_SEL = 3'd6; IN_TAG = 5'd4; tick();
    IN = 25'($urandom()); IMM_SEL = 3'd0; IN_TAG = 5'd5; tick();
    IN_TAG = 5'd6; FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    total++; if ({vld32, vld64} !== 2'b00 || {rdy32, rdy64} !== 2'b11) begin bad++; $display("FAIL flush_state got v=%b%b r=%b%b exp v=00 r=11", vld32, vld64, rdy32, rdy64); end
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({vld32, vld64} !== 2'b00) begin bad++; $display("FAIL flush_ghost_%0d got v=%b%b tag=%0d exp v=00", k, vld32, vld64, tag32); end
    end
  endtask

  task automatic test_reset_mid();
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    IN = 25'($urandom()); IMM_SEL = 3'd4; IN_TAG = 5'd7; tick();
    IN = 25'($urandom()); IMM_SEL = 3'd3; IN_TAG = 5'd8; tick();
    RESET = 1'b0; OUT_READY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if ({out32, out64, tag32, tag64, vld32, vld64, rdy32, rdy64} !== '0) begin
        bad++; $display("FAIL midreset_%0d got out=%h/%h tag=%0d v=%b r=%b exp all 0", k, out32, out64, tag32, vld32, rdy32);
      end
    end
    RESET = 1'b1; IN_TAG = 5'd9;
    tick();
    total++; if ({rdy32, rdy64} !== 2'b11 || {vld32, vld64} !== 2'b00) begin bad++; $display("FAIL midreset_release got r=%b%b v=%b%b exp r=11 v=00", rdy32, rdy64, vld32, vld64); end
    for (int k = 0; k < 8; k++) begin
      IN = 25'($urandom()); IMM_SEL = 3'($urandom()); IN_TAG = 5'(10 + k);
      tick();
      total++; if (vld32 !== 1'b1 || tag32 !== 5'(10 + k) || tag64 !== 5'(10 + k) || out32 !== q[0].e32 || out64 !== q[0].e64) begin
        bad++; $display("FAIL b2b_%0d got v=%b tag=%0d out=%h exp v=1 tag=%0d out=%h", k, vld32, tag32, out32, 10 + k, q[0].e32);
      end
    end
    IN_VALID = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      IN        = 25'($urandom());
      IMM_SEL   = 3'($urandom());
      IN_TAG    = 5'($urandom());
      IN_VALID  = ($urandom_range(0, 9) < 7);
      OUT_READY = ($urandom_range(0, 9) < 6);
      FLUSH     = ($urandom_range(0, 49) == 0);
      tick();
      total++; if (vld32 !== (q.size() > 0) || vld64 !== (q.size() > 0) || rdy32 !== exp_rdy || rdy64 !== exp_rdy) begin
        bad++; $display("FAIL rand_ctl_%0d got v=%b%b r=%b%b exp v=%b r=%b", c, vld32, vld64, rdy32, rdy64, q.size() > 0, exp_rdy);
      end
      if (q.size() > 0) begin
        total++; if (out32 !== q[0].e32 || out64 !== q[0].e64 || tag32 !== q[0].tag || tag64 !== q[0].tag) begin
          bad++; $display("FAIL rand_data_%0d got %h/%h tag=%0d exp %h/%h tag=%0d", c, out32, out64, tag32, q[0].e32, q[0].e64, q[0].tag);
        end
      end
    end
    FLUSH = 1'b0; IN_VALID = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; IN = '0; IMM_SEL = '0; IN_TAG = '0; IN_VALID = 1'b0;
    FLUSH = 1'b0; OUT_READY = 1'b0;
    @(negedge CLK);
    test_reset();
    test_known();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
